// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: an 8-deep byte FIFO feeding an 8N1 / 8E1 / 8O1 serialiser
// with its own per-bit clock divider. txd is registered and idles high.
module uart_tx_fifo #(
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned ADDR_W       = 3,
  parameter int unsigned CLKS_PER_BIT = 5208,
  parameter bit          PARITY_EN    = 1'b0,
  parameter bit          PARITY_ODD   = 1'b0
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              txd,
  output logic              tx_busy
);

  localparam int unsigned     CntW     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned     CntMaxI  = CLKS_PER_BIT - 1;
  localparam logic [CntW-1:0] CntMax   = CntMaxI[CntW-1:0];
  localparam logic [ADDR_W:0] DepthCnt = DEPTH[ADDR_W:0];

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e            state_q;
  logic [CntW-1:0]   bit_cnt_q;
  logic [2:0]        bit_idx_q;
  logic [7:0]        shift_q;
  logic              txd_q;

  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]   count_q, count_d;
  logic              full_q, empty_q, overflow_q;

  logic              push, pop, bit_end;
  logic [2:0]        idx_nxt;

  always_comb begin
    bit_end = (bit_cnt_q == CntMax);
    push    = wr_en && !full_q;
    // Pop when idle, or at the end of a stop bit so frames run back to back.
    pop     = !empty_q && ((state_q == StIdle) || ((state_q == StStop) && bit_end));
    idx_nxt = bit_idx_q + 3'd1;
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + {{ADDR_W{1'b0}}, 1'b1};
    end else if (pop && !push) begin
      count_d = count_q - {{ADDR_W{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge sysclk) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
      end
      count_q <= count_d;
      full_q  <= (count_d == DepthCnt);
      empty_q <= (count_d == '0);
      if (wr_en && full_q) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Storage carries no reset; occupancy alone says which entries are valid.
  always_ff @(posedge sysclk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge sysclk) begin
    if (!reset) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      txd_q     <= 1'b1;
    end else begin
      if (state_q != StIdle) begin
        bit_cnt_q <= bit_end ? '0 : bit_cnt_q + CntW'(1);
      end
      unique case (state_q)
        StIdle: begin
          txd_q <= 1'b1;
          if (pop) begin
            shift_q <= mem_q[rd_ptr_q];
            txd_q   <= 1'b0;
            state_q <= StStart;
          end
        end
        StStart: begin
          if (bit_end) begin
            bit_idx_q <= '0;
            txd_q     <= shift_q[0];
            state_q   <= StData;
          end
        end
        StData: begin
          if (bit_end) begin
            if (bit_idx_q == 3'd7) begin
              if (PARITY_EN) begin
                txd_q   <= (^shift_q) ^ PARITY_ODD;
                state_q <= StParity;
              end else begin
                txd_q   <= 1'b1;
                state_q <= StStop;
              end
            end else begin
              bit_idx_q <= idx_nxt;
              txd_q     <= shift_q[idx_nxt];
            end
          end
        end
        StParity: begin
          if (bit_end) begin
            txd_q   <= 1'b1;
            state_q <= StStop;
          end
        end
        StStop: begin
          if (bit_end) begin
            if (pop) begin
              shift_q <= mem_q[rd_ptr_q];
              txd_q   <= 1'b0;
              state_q <= StStart;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        default: begin
          txd_q   <= 1'b1;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign full     = full_q;
  assign empty    = empty_q;
  assign count    = count_q;
  assign overflow = overflow_q;
  assign txd      = txd_q;
  assign tx_busy  = (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three instances (8N1, 8E1, 8O1), randomized bytes checked cycle by
// cycle against a transaction-level model of queue occupancy and line frames.
module tb_uart_tx_fifo;

  localparam int CPB   = 4;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]      rst_n;
  logic [2:0]      wr_en;
  logic [2:0][7:0] wr_data;
  logic [2:0]      full_w, empty_w, ovf_w, txd_w, busy_w;
  logic [2:0][3:0] count_w;

  uart_tx_fifo #(.DEPTH(8), .ADDR_W(3), .CLKS_PER_BIT(CPB), .PARITY_EN(1'b0), .PARITY_ODD(1'b0))
  dut_n (
    .sysclk(clk), .reset(rst_n[0]), .wr_en(wr_en[0]), .wr_data(wr_data[0]),
    .full(full_w[0]), .empty(empty_w[0]), .count(count_w[0]), .overflow(ovf_w[0]),
    .txd(txd_w[0]), .tx_busy(busy_w[0])
  );

  uart_tx_fifo #(.DEPTH(8), .ADDR_W(3), .CLKS_PER_BIT(CPB), .PARITY_EN(1'b1), .PARITY_ODD(1'b0))
  dut_e (
    .sysclk(clk), .reset(rst_n[1]), .wr_en(wr_en[1]), .wr_data(wr_data[1]),
    .full(full_w[1]), .empty(empty_w[1]), .count(count_w[1]), .overflow(ovf_w[1]),
    .txd(txd_w[1]), .tx_busy(busy_w[1])
  );

  uart_tx_fifo #(.DEPTH(8), .ADDR_W(3), .CLKS_PER_BIT(CPB), .PARITY_EN(1'b1), .PARITY_ODD(1'b1))
  dut_o (
    .sysclk(clk), .reset(rst_n[2]), .wr_en(wr_en[2]), .wr_data(wr_data[2]),
    .full(full_w[2]), .empty(empty_w[2]), .count(count_w[2]), .overflow(ovf_w[2]),
    .txd(txd_w[2]), .tx_busy(busy_w[2])
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Model: queue of accepted bytes, plus the frame currently on the line.
  logic [7:0] m_q[$];
  logic [7:0] m_byte;
  bit         m_active;
  bit         m_ovf;
  int         m_cyc, m_start, m_end;

  // Packed as {txd, busy, full, empty, overflow, count[3:0]}
  logic [8:0] exp_v, obs_v;

  function automatic logic frame_bit(input logic [7:0] b, input int pos, input bit pe,
                                     input bit odd);
    if (pos == 0) return 1'b0;
    if (pos <= 8) return b[pos-1];
    if (pos == 9 && pe) return (^b) ^ odd;
    return 1'b1;
  endfunction

  // Drive one edge on instance sel, advance the model, sample on the following negedge.
  task automatic step(input int sel, input logic rn, input logic we, input logic [7:0] d);
    bit pe, odd, acc, pop, busy;
    int flen, cnt;
    logic t;
    pe   = (sel != 0);
    odd  = (sel == 2);
    flen = pe ? 11 * CPB : 10 * CPB;
    rst_n[sel]   = rn;
    wr_en[sel]   = we;
    wr_data[sel] = d;
    if (!rn) begin
      m_q.delete();
      m_active = 1'b0;
      m_ovf    = 1'b0;
    end else begin
      acc = we && (m_q.size() < DEPTH);
      if (we && !acc) m_ovf = 1'b1;
      pop = (m_q.size() > 0) && (!m_active || m_cyc >= m_end);
      if (pop) begin
        m_byte   = m_q.pop_front();
        m_start  = m_cyc;
        m_end    = m_cyc + flen;
        m_active = 1'b1;
      end
      if (acc) m_q.push_back(d);
    end
    busy  = m_active && (m_cyc < m_end);
    t     = busy ? frame_bit(m_byte, (m_cyc - m_start) / CPB, pe, odd) : 1'b1;
    cnt   = m_q.size();
    exp_v = {t, busy, (cnt == DEPTH), (cnt == 0), m_ovf, cnt[3:0]};
    m_cyc++;
    @(negedge clk);
    wr_en[sel] = 1'b0;
    obs_v = {txd_w[sel], busy_w[sel], full_w[sel], empty_w[sel], ovf_w[sel], count_w[sel]};
  endtask

  task automatic test_reset(input int sel);
    for (int i = 0; i < 2; i++) begin
      step(sel, 1'b0, 1'b1, 8'hFF);
      n_checks++;
      if (obs_v !== exp_v)
        $display("FAIL reset dut%0d cyc=%0d txd/busy/full/empty/ovf/count got=%b want=%b",
                 sel, m_cyc, obs_v, exp_v);
      else n_pass++;
    end
  endtask

  task automatic test_single(input logic [7:0] b);
    for (int c = 0; c < 46; c++) begin
      step(0, 1'b1, (c == 0), b);
      n_checks++;
      if (obs_v !== exp_v)
        $display("FAIL single byte=%h cyc=%0d txd/busy/full/empty/ovf/count got=%b want=%b",
                 b, c, obs_v, exp_v);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back(input logic [7:0] b0, input logic [7:0] b1);
    for (int c = 0; c < 88; c++) begin
      step(0, 1'b1, (c < 2), (c == 0) ? b0 : b1);
      n_checks++;
      if (obs_v !== exp_v)
        $display("FAIL back_to_back cyc=%0d txd/busy/full/empty/ovf/count got=%b want=%b",
                 c, obs_v, exp_v);
      else n_pass++;
    end
  endtask

  // Fill during the first frame; a push lands on the STOP-end pop with count=3.
  task automatic test_push_pop_stop;
    for (int c = 0; c < 4 * 40 + 10; c++) begin
      step(0, 1'b1, (c < 4) || (c == 41), 8'($urandom));
      n_checks++;
      if (obs_v !== exp_v)
        $display("FAIL push_pop_stop cyc=%0d txd/busy/full/empty/ovf/count got=%b want=%b",
                 c, obs_v, exp_v);
      else n_pass++;
    end
  endtask

  task automatic test_overflow;
    for (int c = 0; c < 9 * 40 + 12; c++) begin
      step(0, 1'b1, (c < 11), 8'($urandom));
      n_checks++;
      if (obs_v !== exp_v)
        $display("FAIL overflow cyc=%0d txd/busy/full/empty/ovf/count got=%b want=%b",
                 c, obs_v, exp_v);
      else n_pass++;
    end
  endtask

  // Reset lands while data bit 3 is on the line; overflow is still set from before.
  task automatic test_reset_mid_frame;
    for (int c = 0; c < 18; c++) begin
      step(0, 1'b1, (c == 0), 8'($urandom));
      n_checks++;
      if (obs_v !== exp_v)
        $display("FAIL mid_frame_pre cyc=%0d txd/busy/full/empty/ovf/count got=%b want=%b",
                 c, obs_v, exp_v);
      else n_pass++;
    end
    step(0, 1'b0, 1'b0, 8'h00);
    n_checks++;
    if (obs_v !== exp_v)
      $display("FAIL mid_frame_reset txd/busy/full/empty/ovf/count got=%b want=%b", obs_v, exp_v);
    else n_pass++;
    for (int c = 0; c < 45; c++) begin
      step(0, 1'b1, (c == 0), 8'($urandom));
      n_checks++;
      if (obs_v !== exp_v)
        $display("FAIL mid_frame_post cyc=%0d txd/busy/full/empty/ovf/count got=%b want=%b",
                 c, obs_v, exp_v);
      else n_pass++;
    end
  endtask

  task automatic test_parity(input int sel);
    for (int c = 0; c < 2 * 44 + 6; c++) begin
      step(sel, 1'b1, (c < 2), (c == 0) ? 8'h07 : 8'($urandom));
      n_checks++;
      if (obs_v !== exp_v)
        $display("FAIL parity dut%0d cyc=%0d txd/busy/full/empty/ovf/count got=%b want=%b",
                 sel, c, obs_v, exp_v);
      else n_pass++;
    end
  endtask

  task automatic test_random;
    for (int c = 0; c < 900; c++) begin
      step(0, 1'b1, (c < 450) && ($urandom_range(0, 24) == 0), 8'($urandom));
      n_checks++;
      if (obs_v !== exp_v)
        $display("FAIL random cyc=%0d txd/busy/full/empty/ovf/count got=%b want=%b",
                 c, obs_v, exp_v);
      else n_pass++;
    end
  endtask

  initial begin
    rst_n   = 3'b000;
    wr_en   = 3'b000;
    wr_data = '0;
    m_cyc   = 0;
    m_start = 0;
    m_end   = 0;
    m_byte  = 8'h00;
    m_active = 1'b0;
    m_ovf   = 1'b0;
    @(negedge clk);
    test_reset(0);
    test_single(8'h55);
    test_single(8'($urandom));
    test_back_to_back(8'hA3, 8'h0F);
    test_push_pop_stop();
    test_overflow();
    test_reset_mid_frame();
    test_random();
    test_reset(1);
    test_parity(1);
    test_reset(2);
    test_parity(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
